// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and default geometry for the burst master
package mem_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_RF_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// rtl/mem_rd_fifo.sv - synchronous read-data FIFO with occupancy count
module mem_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst command engine driving the single-port memory port
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int RF_DEPTH   = DEF_RF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [WIDTH-1:0]      wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready
);

  localparam int CW = $clog2(RF_DEPTH) + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH:0]    beats_left;
  logic                  rsp_pend;
  logic                  rsp_rd;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           credit_used;
  logic                  cmd_take;
  logic                  issue;
  logic                  last_beat;
  logic                  drain_done;

  assign cmd_ready  = (state == IDLE) && !rst;
  assign wd_ready   = (state == WRITE) && !rst;
  assign cmd_take   = cmd_valid && cmd_ready;
  assign rd_valid   = (fifo_cnt != '0);
  assign last_beat  = (beats_left == (LEN_WIDTH+1)'(1));
  assign drain_done = !rsp_pend && !mem_valid;

  // Reads already on the wire or awaiting data each hold a FIFO slot.
  assign credit_used = (CW+1)'(fifo_cnt)
                     + (CW+1)'(mem_valid && !mem_wr_rd)
                     + (CW+1)'(rsp_pend);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:  if (cmd_take) state_nxt = cmd_wr ? WRITE : READ;
      WRITE: begin
        issue = wd_valid;
        if (issue && last_beat) state_nxt = DRAIN;
      end
      READ: begin
        issue = (credit_used < (CW+1)'(RF_DEPTH));
        if (issue && last_beat) state_nxt = DRAIN;
      end
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      mem_valid  <= 1'b0;
      mem_wr_rd  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_pend   <= 1'b0;
      rsp_rd     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_valid <= issue;
      rsp_pend  <= mem_valid;
      rsp_rd    <= mem_valid && !mem_wr_rd;
      done      <= (state == DRAIN) && drain_done;
      if (rsp_pend && !mem_ready) err <= 1'b1;
      if (cmd_take) begin
        cur_addr   <= cmd_addr;
        beats_left <= (LEN_WIDTH+1)'(cmd_len) + (LEN_WIDTH+1)'(1);
      end
      if (issue) begin
        mem_wr_rd  <= (state == WRITE);
        mem_addr   <= cur_addr;
        cur_addr   <= (cur_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_addr + ADDR_WIDTH'(1);
        beats_left <= beats_left - (LEN_WIDTH+1)'(1);
        if (state == WRITE) mem_wdata <= wd_data;
      end
    end
  end

  mem_rd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RF_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_rd),
    .push_data (mem_rdata),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - randomized self-checking bench with memory model and reference array
module tb_mem_burst_master;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = '0;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        mem_valid;
  logic        mem_wr_rd;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic        rd_rand = 1'b0;
  logic        rd_hold = 1'b1;
  logic        rd_rand_bit = 1'b0;
  assign rd_ready = rd_rand ? rd_rand_bit : rd_hold;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          beats_total = 0;
  int          drop_at = -1;
  int          bp_addr = 0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  bit          known [1024];
  logic [31:0] wq [$];
  req_t        mlog [$];
  logic [31:0] rxq [$];
  int          rxc [$];

  mem_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // memory model: acks one clk after each request, optionally withholds one ack
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_rand_bit <= 1'($urandom_range(0, 1));
    if (rst) mem_ready <= 1'b0;
    else     mem_ready <= mem_valid && (beats_total != drop_at);
    if (mem_valid) begin
      beats_total <= beats_total + 1;
      if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
      else           mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    req_t r;
    if (mem_valid) begin
      r.cyc = cyc; r.wr = mem_wr_rd; r.addr = mem_addr; r.data = mem_wdata;
      mlog.push_back(r);
    end
    if (rd_valid && rd_ready) begin
      rxq.push_back(rd_data);
      rxc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic send_cmd(input logic wr, input int a, input int l);
    int g = 0;
    logic ok = 1'b0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = 10'(a); cmd_len = 8'(l);
    while (!ok && g < 300) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; g++;
    end
    cmd_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL cmd_accept got=timeout exp=cmd_ready"); end
  endtask

  task automatic drive_write(input bit gaps);
    int i = 0;
    int g = 0;
    bit phase = 1'b0;
    while (i < wq.size() && g < 3000) begin
      if (gaps && phase) wd_valid = 1'b0;
      else begin wd_valid = 1'b1; wd_data = wq[i]; end
      @(negedge clk);
      if (wd_valid && wd_ready) i++;
      phase = ~phase;
      @(posedge clk); #1; g++;
    end
    wd_valid = 1'b0;
    total++;
    if (i != wq.size()) begin bad++; $display("FAIL wr_stream got=%0d exp=%0d beats", i, wq.size()); end
  endtask

  task automatic wait_done(input int d0);
    int g = 0;
    while (done_cnt == d0 && g < 3000) begin @(posedge clk); #1; g++; end
    total++;
    if (done_cnt == d0) begin bad++; $display("FAIL done_wait got=timeout exp=done"); end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (rd_valid && g < 1000) begin @(posedge clk); #1; g++; end
    total++;
    if (rd_valid) begin bad++; $display("FAIL drain_wait got=rd_valid exp=empty"); end
  endtask

  task automatic fill_wq(input int a, input int n, input bit fixed);
    wq.delete();
    for (int i = 0; i < n; i++) begin
      wq.push_back(fixed ? 32'hA0 + 32'(i) : $urandom);
      ref_mem[(a + i) % 1024] = wq[i];
      known[(a + i) % 1024] = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (mem_valid !== 1'b0 || rd_valid !== 1'b0 || wd_ready !== 1'b0) begin
      bad++; $display("FAIL rst_outputs got=%b%b%b exp=000", mem_valid, rd_valid, wd_ready); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_done_err got=%b%b exp=00", done, err); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_wrap();
    int mb = mlog.size();
    int d0 = done_cnt;
    fill_wq(1022, 4, 1'b1);
    send_cmd(1'b1, 1022, 3);
    drive_write(1'b0);
    wait_done(d0);
    repeat (4) @(posedge clk); #1;
    total++; if (mlog.size() - mb != 4) begin bad++; $display("FAIL wr_beats got=%0d exp=4", mlog.size() - mb); end
    for (int i = 0; i < 4 && mb + i < mlog.size(); i++) begin
      int ea = (1022 + i) % 1024;
      total++;
      if (mlog[mb+i].addr !== 10'(ea) || mlog[mb+i].data !== 32'hA0 + 32'(i) || mlog[mb+i].wr !== 1'b1) begin
        bad++; $display("FAIL wr_req[%0d] got=%h/%h/%b exp=%h/%h/1", i, mlog[mb+i].addr, mlog[mb+i].data,
                        mlog[mb+i].wr, 10'(ea), 32'hA0 + 32'(i));
      end
      if (i > 0) begin
        total++;
        if (mlog[mb+i].cyc != mlog[mb].cyc + i) begin
          bad++; $display("FAIL wr_rate[%0d] got=%0d exp=%0d", i, mlog[mb+i].cyc - mlog[mb].cyc, i); end
      end
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL wr_done_cnt got=%0d exp=1", done_cnt - d0); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", err); end
  endtask

  task automatic test_read_back();
    int rb = rxq.size();
    int d0 = done_cnt;
    rd_rand = 1'b0; rd_hold = 1'b1;
    send_cmd(1'b0, 1022, 3);
    wait_done(d0);
    wait_drain();
    total++; if (rxq.size() - rb != 4) begin bad++; $display("FAIL rb_beats got=%0d exp=4", rxq.size() - rb); end
    for (int i = 0; i < 4 && rb + i < rxq.size(); i++) begin
      total++;
      if (rxq[rb+i] !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL rb_data[%0d] got=%h exp=%h", i, rxq[rb+i], 32'hA0 + 32'(i)); end
      if (i > 0) begin
        total++;
        if (rxc[rb+i] != rxc[rb] + i) begin bad++; $display("FAIL rb_rate[%0d] got=%0d exp=%0d", i, rxc[rb+i] - rxc[rb], i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int mb, rb, d0, nrd, nbad;
    bp_addr = $urandom_range(0, 1023);
    fill_wq(bp_addr, 16, 1'b0);
    d0 = done_cnt;
    send_cmd(1'b1, bp_addr, 15);
    drive_write(1'b0);
    wait_done(d0);
    rd_hold = 1'b0;
    mb = mlog.size(); rb = rxq.size(); d0 = done_cnt;
    send_cmd(1'b0, bp_addr, 15);
    repeat (20) @(posedge clk);
    @(negedge clk);
    nrd = 0;
    for (int i = mb; i < mlog.size(); i++) if (!mlog[i].wr) nrd++;
    total++; if (nrd != 4) begin bad++; $display("FAIL bp_issued got=%0d exp=4", nrd); end
    total++; if (mem_valid !== 1'b0 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stall got=mv%b rv%b exp=mv0 rv1", mem_valid, rd_valid); end
    @(posedge clk); #1; rd_hold = 1'b1;
    wait_done(d0);
    wait_drain();
    total++; if (rxq.size() - rb != 16) begin bad++; $display("FAIL bp_beats got=%0d exp=16", rxq.size() - rb); end
    nbad = 0;
    for (int i = 0; i < 16 && rb + i < rxq.size(); i++) if (rxq[rb+i] !== ref_mem[(bp_addr + i) % 1024]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL bp_data got=%0d wrong exp=0 wrong", nbad); end
  endtask

  task automatic test_write_gaps();
    int a = $urandom_range(0, 1023);
    int mb = mlog.size();
    int d0 = done_cnt;
    int nbad = 0;
    fill_wq(a, 8, 1'b0);
    send_cmd(1'b1, a, 7);
    drive_write(1'b1);
    wait_done(d0);
    total++; if (mlog.size() - mb != 8) begin bad++; $display("FAIL gap_beats got=%0d exp=8", mlog.size() - mb); end
    for (int i = 1; i < 8 && mb + i < mlog.size(); i++)
      if (mlog[mb+i].cyc - mlog[mb+i-1].cyc != 2 || mlog[mb+i].addr !== 10'((a + i) % 1024)) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL gap_spacing got=%0d wrong exp=0 wrong", nbad); end
    nbad = 0;
    for (int i = 0; i < 8; i++) if (mem[(a + i) % 1024] !== ref_mem[(a + i) % 1024]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL gap_mem got=%0d wrong exp=0 wrong", nbad); end
  endtask

  task automatic test_reset_mid();
    int mb = mlog.size();
    int d0 = done_cnt;
    int g = 0;
    rd_hold = 1'b1;
    send_cmd(1'b0, $urandom_range(0, 1023), 7);
    @(negedge clk);
    while (mlog.size() - mb < 2 && g < 50) begin @(negedge clk); g++; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (mem_valid !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs got=mv%b rv%b exp=mv0 rv0", mem_valid, rd_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); end
    repeat (10) @(posedge clk); #1;
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0 pulses", done_cnt - d0); end
  endtask

  task automatic test_err();
    int rb = rxq.size();
    int d0 = done_cnt;
    int nbad = 0;
    drop_at = beats_total + 1;
    send_cmd(1'b0, bp_addr, 3);
    wait_done(d0);
    wait_drain();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    total++; if (rxq.size() - rb != 4) begin bad++; $display("FAIL err_beats got=%0d exp=4", rxq.size() - rb); end
    for (int i = 0; i < 4 && rb + i < rxq.size(); i++) if (rxq[rb+i] !== ref_mem[(bp_addr + i) % 1024]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL err_data got=%0d wrong exp=0 wrong", nbad); end
    d0 = done_cnt;
    fill_wq(bp_addr, 2, 1'b0);
    send_cmd(1'b1, bp_addr, 1);
    drive_write(1'b0);
    wait_done(d0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    drop_at = -1;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    rd_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int a = $urandom_range(0, 1023);
      int n = $urandom_range(1, 24);
      int off = $urandom_range(0, n - 1);
      int m = $urandom_range(1, n - off);
      int rb, d0;
      int nbad = 0;
      fill_wq(a, n, 1'b0);
      d0 = done_cnt;
      send_cmd(1'b1, a, n - 1);
      drive_write(1'($urandom_range(0, 1)));
      wait_done(d0);
      rb = rxq.size(); d0 = done_cnt;
      send_cmd(1'b0, (a + off) % 1024, m - 1);
      wait_done(d0);
      wait_drain();
      total++; if (rxq.size() - rb != m) begin bad++; $display("FAIL b2b_beats[%0d] got=%0d exp=%0d", k, rxq.size() - rb, m); end
      for (int i = 0; i < m && rb + i < rxq.size(); i++) if (rxq[rb+i] !== ref_mem[(a + off + i) % 1024]) nbad++;
      total++; if (nbad != 0) begin bad++; $display("FAIL b2b_data[%0d] got=%0d wrong exp=0 wrong", k, nbad); end
    end
    rd_rand = 1'b0;
    begin
      int nbad = 0;
      for (int i = 0; i < 1024; i++) if (known[i] && mem[i] !== ref_mem[i]) nbad++;
      total++; if (nbad != 0) begin bad++; $display("FAIL final_mem got=%0d wrong exp=0 wrong", nbad); end
    end
  endtask

  initial begin
    test_reset();
    test_write_wrap();
    test_read_back();
    test_backpressure();
    test_write_gaps();
    test_reset_mid();
    test_err();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
